// File: rtl/comparator_n_bit.sv
// comparator_n_bit: parameterised N-bit magnitude comparator with registered outputs.
//
// A compare is taken on every rising edge where in_valid is high; one clock later
// exactly one of Lesser/Greater/Equal is set and out_valid pulses for one cycle.
// When in_valid is low the flags hold and out_valid drops.
//
// Parameters:
//   N      - operand width in bits (1..64)
//   SIGNED - 0: unsigned operands, 1: two's-complement operands
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset; clears all outputs
//   in_valid  - qualifies A/B for a compare this cycle
//   A, B      - operands
//   Lesser    - registered, A < B
//   Greater   - registered, A > B
//   Equal     - registered, A == B (bitwise, independent of SIGNED)
//   Max, Min  - registered larger/smaller operand (only with COMPARATOR_MAXMIN_EN)
//   out_valid - registered one-cycle strobe marking a fresh result
//
// Optional feature: define COMPARATOR_MAXMIN_EN to add the Max/Min outputs.

module comparator_n_bit #(
  parameter int unsigned N      = 3,
  parameter bit          SIGNED = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         Lesser,
  output logic         Greater,
  output logic         Equal,
`ifdef COMPARATOR_MAXMIN_EN
  output logic [N-1:0] Max,
  output logic [N-1:0] Min,
`endif
  output logic         out_valid
);

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so a single unsigned comparator serves both modes.
  logic [N-1:0] a_key;
  logic [N-1:0] b_key;
  logic         lt;
  logic         eq;
  logic         gt;

  always_comb begin
    a_key = A;
    b_key = B;
    if (SIGNED) begin
      a_key[N-1] = ~A[N-1];
      b_key[N-1] = ~B[N-1];
    end
    lt = (a_key < b_key);
    eq = (A == B);
    gt = ~lt & ~eq;
  end

  logic lesser_q;
  logic greater_q;
  logic equal_q;
  logic out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lesser_q    <= 1'b0;
      greater_q   <= 1'b0;
      equal_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        lesser_q  <= lt;
        greater_q <= gt;
        equal_q   <= eq;
      end
    end
  end

  assign Lesser    = lesser_q;
  assign Greater   = greater_q;
  assign Equal     = equal_q;
  assign out_valid = out_valid_q;

`ifdef COMPARATOR_MAXMIN_EN
  // On equality both outputs take A (A == B bitwise, so the choice is invisible).
  logic [N-1:0] max_d;
  logic [N-1:0] min_d;
  logic [N-1:0] max_q;
  logic [N-1:0] min_q;

  always_comb begin
    max_d = lt ? B : A;
    min_d = lt ? A : B;
    if (eq) begin
      max_d = A;
      min_d = A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      min_q <= '0;
    end else if (in_valid) begin
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign Max = max_q;
  assign Min = min_q;
`endif

endmodule

// File: tb/tb_comparator_n_bit.sv
// Testbench for comparator_n_bit: three instances (N=3 unsigned, N=3 signed, N=1
// unsigned). Stimulus pushes expected results into a per-instance queue; a monitor
// per instance pops and compares whenever out_valid is seen on the falling edge.
module tb_comparator_n_bit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       l;
    logic       g;
    logic       e;
    logic [2:0] mx;
    logic [2:0] mn;
  } exp_t;

  exp_t q3u[$];
  exp_t q3s[$];
  exp_t q1u[$];
  exp_t x3u, x3s, x1u;

  int n_tests = 0;
  int n_fail  = 0;

  // N=3 unsigned
  logic       v3u = 1'b0;
  logic [2:0] a3u = '0, b3u = '0;
  logic       l3u, g3u, e3u, ov3u;
  logic [2:0] mx3u, mn3u;
  // N=3 signed
  logic       v3s = 1'b0;
  logic [2:0] a3s = '0, b3s = '0;
  logic       l3s, g3s, e3s, ov3s;
  logic [2:0] mx3s, mn3s;
  // N=1 unsigned
  logic       v1u = 1'b0;
  logic [0:0] a1u = '0, b1u = '0;
  logic       l1u, g1u, e1u, ov1u;
  logic [0:0] mx1u, mn1u;

`ifndef COMPARATOR_MAXMIN_EN
  assign mx3u = '0; assign mn3u = '0;
  assign mx3s = '0; assign mn3s = '0;
  assign mx1u = '0; assign mn1u = '0;
`endif

  comparator_n_bit #(.N(3), .SIGNED(1'b0)) u3u (
    .clk(clk), .rst(rst), .in_valid(v3u), .A(a3u), .B(b3u),
    .Lesser(l3u), .Greater(g3u), .Equal(e3u),
`ifdef COMPARATOR_MAXMIN_EN
    .Max(mx3u), .Min(mn3u),
`endif
    .out_valid(ov3u)
  );

  comparator_n_bit #(.N(3), .SIGNED(1'b1)) u3s (
    .clk(clk), .rst(rst), .in_valid(v3s), .A(a3s), .B(b3s),
    .Lesser(l3s), .Greater(g3s), .Equal(e3s),
`ifdef COMPARATOR_MAXMIN_EN
    .Max(mx3s), .Min(mn3s),
`endif
    .out_valid(ov3s)
  );

  comparator_n_bit #(.N(1), .SIGNED(1'b0)) u1u (
    .clk(clk), .rst(rst), .in_valid(v1u), .A(a1u), .B(b1u),
    .Lesser(l1u), .Greater(g1u), .Equal(e1u),
`ifdef COMPARATOR_MAXMIN_EN
    .Max(mx1u), .Min(mn1u),
`endif
    .out_valid(ov1u)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  function automatic exp_t mk(input logic l, input logic g, input logic e,
                              input logic [2:0] mx, input logic [2:0] mn);
    exp_t x;
    x.l = l; x.g = g; x.e = e; x.mx = mx; x.mn = mn;
    return x;
  endfunction

  // Reference for N=3: integer compare after interpreting the operands.
  function automatic exp_t model3(input logic [2:0] a, input logic [2:0] b, input bit sgn);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (sgn && ia >= 4) ia -= 8;
    if (sgn && ib >= 4) ib -= 8;
    return mk(ia < ib, ia > ib, ia == ib, (ia >= ib) ? a : b, (ia <= ib) ? a : b);
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (ov3u === 1'b1) begin
      if (q3u.size() == 0) check("u3u spurious out_valid", 64'(ov3u), 64'd0);
      else begin
        x3u = q3u.pop_front();
        check("u3u flags", {l3u, g3u, e3u}, {x3u.l, x3u.g, x3u.e});
`ifdef COMPARATOR_MAXMIN_EN
        check("u3u max", mx3u, x3u.mx);
        check("u3u min", mn3u, x3u.mn);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (ov3s === 1'b1) begin
      if (q3s.size() == 0) check("u3s spurious out_valid", 64'(ov3s), 64'd0);
      else begin
        x3s = q3s.pop_front();
        check("u3s flags", {l3s, g3s, e3s}, {x3s.l, x3s.g, x3s.e});
`ifdef COMPARATOR_MAXMIN_EN
        check("u3s max", mx3s, x3s.mx);
        check("u3s min", mn3s, x3s.mn);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (ov1u === 1'b1) begin
      if (q1u.size() == 0) check("u1u spurious out_valid", 64'(ov1u), 64'd0);
      else begin
        x1u = q1u.pop_front();
        check("u1u flags", {l1u, g1u, e1u}, {x1u.l, x1u.g, x1u.e});
`ifdef COMPARATOR_MAXMIN_EN
        check("u1u max", mx1u, x1u.mx);
        check("u1u min", mn1u, x1u.mn);
`endif
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic go3u(input logic [2:0] a, input logic [2:0] b, input exp_t x);
    a3u = a; b3u = b; v3u = 1'b1;
    q3u.push_back(x);
    @(posedge clk); #1;
    v3u = 1'b0;
  endtask

  task automatic go3s(input logic [2:0] a, input logic [2:0] b, input exp_t x);
    a3s = a; b3s = b; v3s = 1'b1;
    q3s.push_back(x);
    @(posedge clk); #1;
    v3s = 1'b0;
  endtask

  task automatic go1u(input logic a, input logic b, input exp_t x);
    a1u = a; b1u = b; v1u = 1'b1;
    q1u.push_back(x);
    @(posedge clk); #1;
    v1u = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #17;
    check("reset flags u3u", {l3u, g3u, e3u, ov3u}, 4'b0000);
    check("reset flags u3s", {l3s, g3s, e3s, ov3s}, 4'b0000);
    check("reset flags u1u", {l1u, g1u, e1u, ov1u}, 4'b0000);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-release idle u3u", {l3u, g3u, e3u, ov3u}, 4'b0000);

    // Directed, hand-computed: {l,g,e}, max, min
    go3u(3'd3, 3'd5, mk(1, 0, 0, 3'd5, 3'd3));
    go3u(3'd7, 3'd0, mk(0, 1, 0, 3'd7, 3'd0));
    go3u(3'd4, 3'd4, mk(0, 0, 1, 3'd4, 3'd4));
    go3u(3'd5, 3'd2, mk(0, 1, 0, 3'd5, 3'd2));
    go3u(3'd3, 3'd3, mk(0, 0, 1, 3'd3, 3'd3));
    go3u(3'b111, 3'b001, mk(0, 1, 0, 3'b111, 3'b001));
    go3u(3'b011, 3'b100, mk(1, 0, 0, 3'b100, 3'b011));

    go3s(3'b111, 3'b001, mk(1, 0, 0, 3'b001, 3'b111));
    go3s(3'b011, 3'b100, mk(0, 1, 0, 3'b011, 3'b100));
    go3s(3'b100, 3'b011, mk(1, 0, 0, 3'b011, 3'b100));
    go3s(3'b000, 3'b111, mk(0, 1, 0, 3'b000, 3'b111));

    go1u(1'b0, 1'b0, mk(0, 0, 1, 3'd0, 3'd0));
    go1u(1'b0, 1'b1, mk(1, 0, 0, 3'd1, 3'd0));
    go1u(1'b1, 1'b0, mk(0, 1, 0, 3'd1, 3'd0));
    go1u(1'b1, 1'b1, mk(0, 0, 1, 3'd1, 3'd1));

    // Back-to-back sweeps of all 64 pairs in both modes
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) begin
        a3s = 3'(a); b3s = 3'(b); v3s = 1'b1;
        q3s.push_back(model3(3'(a), 3'(b), 1'b1));
        go3u(3'(a), 3'(b), model3(3'(a), 3'(b), 1'b0));
      end
    v3s = 1'b0;

    // Hold: flags keep the last compare while in_valid is low
    go3u(3'd2, 3'd6, mk(1, 0, 0, 3'd6, 3'd2));
    a3u = 3'd6; b3u = 3'd2;
    @(posedge clk); #1;
    check("hold out_valid", 64'(ov3u), 64'd0);
    check("hold Lesser", 64'(l3u), 64'd1);
    check("hold Greater", 64'(g3u), 64'd0);
`ifdef COMPARATOR_MAXMIN_EN
    check("hold max", mx3u, 3'd6);
`endif

    // Reset during a valid cycle: outputs clear without a clock edge
    go3u(3'd3, 3'd5, mk(1, 0, 0, 3'd5, 3'd3));
    @(negedge clk); #1;
    a3u = 3'd7; b3u = 3'd0; v3u = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("async reset u3u", {l3u, g3u, e3u, ov3u}, 4'b0000);
`ifdef COMPARATOR_MAXMIN_EN
    check("async reset max/min", {mx3u, mn3u}, 6'd0);
`endif
    @(posedge clk); #1;
    check("reset beats valid", {l3u, g3u, e3u, ov3u}, 4'b0000);
    v3u = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle after reset", {l3u, g3u, e3u, ov3u}, 4'b0000);

    // Compare resumes normally after reset
    go3u(3'd1, 3'd1, mk(0, 0, 1, 3'd1, 3'd1));

    repeat (3) @(posedge clk);
    #1;
    check("u3u queue drained", 64'(q3u.size()), 64'd0);
    check("u3s queue drained", 64'(q3s.size()), 64'd0);
    check("u1u queue drained", 64'(q1u.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
